// File: rtl/oifs_tx_arbiter.sv
// Two-port round-robin burst arbiter feeding oifs_tx_interface through a
// one-entry output register; each beat is tagged with its port's channel bit.
module oifs_tx_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_en,
  input  logic              i_valid0,
  input  logic [DATA_W-1:0] i_data0,
  input  logic              i_last0,
  input  logic              i_channel0,
  output logic              o_ready0,
  input  logic              i_valid1,
  input  logic [DATA_W-1:0] i_data1,
  input  logic              i_last1,
  input  logic              i_channel1,
  output logic              o_ready1,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_channel,
  input  logic              i_ready,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q;
  logic               last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         grant_q;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic               channel_q;

  logic [1:0]         elig;
  logic [1:0]         pick;
  logic [1:0]         accept;
  logic               beat_acc;
  logic               burst_end;
  logic               sel_last;
  logic               sel_channel;
  logic [DATA_W-1:0]  sel_data;

  // A slot opens when the register is empty or drains this cycle.
  assign o_ready0 = grant_q[0] && (!valid_q || i_ready);
  assign o_ready1 = grant_q[1] && (!valid_q || i_ready);

  assign accept   = {i_valid1 && o_ready1, i_valid0 && o_ready0};
  assign beat_acc = |accept;

  assign sel_data    = grant_q[1] ? i_data1    : i_data0;
  assign sel_last    = grant_q[1] ? i_last1    : i_last0;
  assign sel_channel = grant_q[1] ? i_channel1 : i_channel0;

  assign burst_end = beat_acc && (sel_last || (cnt_q == CNT_LIMIT));

  // On contention the port that was not served last wins.
  assign elig = {i_valid1 && i_en[1], i_valid0 && i_en[0]};
  assign pick = (elig == 2'b11) ? (last_q ? 2'b01 : 2'b10) : elig;

  // NOTE: every register here is updated with <= so all of them sample the
  // same pre-edge values; blocking = would let later lines see new state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      grant_q   <= 2'b00;
      valid_q   <= 1'b0;
      data_q    <= '0;
      channel_q <= 1'b0;
    end else begin
      if (beat_acc) begin
        valid_q   <= 1'b1;
        data_q    <= sel_data;
        channel_q <= sel_channel;
      end else if (i_ready) begin
        valid_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (|elig) begin
            state_q <= BURST;
            grant_q <= pick;
            cnt_q   <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= grant_q[1];
            cnt_q   <= '0;
          end else if (beat_acc) begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_channel = channel_q;
  assign o_grant   = grant_q;
  assign o_busy    = (state_q == BURST);

endmodule
